tt_um_top: RTL and testbench

//  TinyTapeout top: 8-bit accumulator CPU with 32x8 register-file memory and a parallel boot loader.

---
 rtl/tt_cpu_pkg.sv | 17 +
 rtl/tt_cpu_if.sv | 13 +
 rtl/tt_cpu_core.sv | 77 +++++++
 rtl/tt_um_top.sv | 77 +++++++
 tb/tb_tt_um_top.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_cpu_pkg.sv
// Shared types and constants for the TinyTapeout accumulator CPU.
// Opcodes live in ir[7:5], the operand address in ir[4:0].
package tt_cpu_pkg;
    localparam int ADDR_W    = 5;
    localparam int MEM_DEPTH = 32;

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_STA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_JZ  = 3'd5;
    localparam logic [2:0] OP_OUT = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    typedef enum logic {FETCH, EXEC} state_e;
endpackage

// File: rtl/tt_cpu_if.sv
// Memory port between the CPU core (master) and the register-file memory (slave).
// Reads are combinational; a write lands on the next clock edge.
interface tt_cpu_if;
    import tt_cpu_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_dat;
    logic              wr_vld;
    logic [7:0]        wr_dat;

    modport master (output addr, output wr_vld, output wr_dat, input rd_dat);
    modport slave  (input addr, input wr_vld, input wr_dat, output rd_dat);
endinterface

// File: rtl/tt_cpu_core.sv
// Two-state accumulator CPU: FETCH then EXEC, one instruction per two enabled cycles.
// hold (boot mode) parks the core at pc 0 with acc cleared; ena=0 or halt freeze it.
module tt_cpu_core
    import tt_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            hold,
    tt_cpu_if.master        mem,
    output logic [7:0]      out_dat
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        ir_q, ir_d;
    logic              halted_q, halted_d;
    logic [7:0]        out_q, out_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        ir_d       = ir_q;
        halted_d   = halted_q;
        out_d      = out_q;
        mem.addr   = (state_q == FETCH) ? pc_q : ir_q[ADDR_W-1:0];
        mem.wr_vld = 1'b0;
        mem.wr_dat = acc_q;

        if (hold) begin
            state_d  = FETCH;
            pc_d     = '0;
            acc_d    = '0;
            halted_d = 1'b0;
        end else if (ena && !halted_q) begin
            if (state_q == FETCH) begin
                ir_d    = mem.rd_dat;
                pc_d    = pc_q + 5'd1;
                state_d = EXEC;
            end else begin
                state_d = FETCH;
                case (ir_q[7:5])
                    OP_LDA: acc_d = mem.rd_dat;
                    OP_STA: mem.wr_vld = 1'b1;
                    OP_ADD: acc_d = acc_q + mem.rd_dat;
                    OP_SUB: acc_d = acc_q - mem.rd_dat;
                    OP_JMP: pc_d = ir_q[ADDR_W-1:0];
                    OP_JZ:  if (acc_q == 8'h00) pc_d = ir_q[ADDR_W-1:0];
                    OP_OUT: out_d = acc_q;
                    OP_HLT: halted_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            acc_q    <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
            out_q    <= out_d;
        end
    end

    assign out_dat = out_q;
endmodule

// File: rtl/tt_um_top.sv
// TinyTapeout top: 32x8 memory, parallel boot loader with synchronized strobe/boot, CPU core.
// Loader writes one byte per synchronized strobe rising edge; uio pins are inputs only.
module tt_um_top
    import tt_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [7:0]        mem_q [MEM_DEPTH];
    logic [7:0]        mem_d [MEM_DEPTH];
    logic              strb_meta_q, strb_sync_q, strb_prev_q;
    logic              boot_meta_q, boot_sync_q;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ld_wr;
    logic              unused_ok;

    tt_cpu_if bus ();

    tt_cpu_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .hold    (boot_sync_q),
        .mem     (bus.master),
        .out_dat (uo_out)
    );

    assign ld_wr      = boot_sync_q & strb_sync_q & ~strb_prev_q;
    assign bus.rd_dat = mem_q[bus.addr];

    always_comb begin
        ld_addr_d = ld_addr_q;
        if (!boot_sync_q)
            ld_addr_d = '0;
        else if (ld_wr)
            ld_addr_d = ld_addr_q + 5'd1;
    end

    // Loader and core never write together: the core is held whenever boot is active.
    always_comb begin
        mem_d = mem_q;
        if (ld_wr)
            mem_d[ld_addr_q] = uio_in;
        else if (bus.wr_vld)
            mem_d[bus.addr] = bus.wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            strb_meta_q <= 1'b0;
            strb_sync_q <= 1'b0;
            strb_prev_q <= 1'b0;
            boot_meta_q <= 1'b0;
            boot_sync_q <= 1'b0;
            ld_addr_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            strb_meta_q <= ui_in[0];
            strb_sync_q <= strb_meta_q;
            strb_prev_q <= strb_sync_q;
            boot_meta_q <= ui_in[7];
            boot_sync_q <= boot_meta_q;
            ld_addr_q   <= ld_addr_d;
        end
    end

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ui_in[6:1]};
endmodule

// File: tb/tb_tt_um_top.sv
// Bench for tt_um_top: instruction-level model predicts the sequence of uo_out values,
// a per-cycle monitor tracks the DUT against it, plus directed programs with literal results.
module tb_tt_um_top;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_top dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] prog [32];
    logic [7:0] lbytes [$];
    logic [7:0] m_outs [$];
    int         m_steps;
    bit         m_halted;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         idx;
    bit         chk_en = 0;
    bit         ena_rand = 0;
    bit         ena_force0 = 0;
    int         en_cnt = 0;
    logic [7:0] last_out = 8'h00;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level reference: runs the program in prog[] until HLT or a step cap.
    task automatic model_run();
        logic [7:0] mm [32];
        logic [7:0] acc, ir;
        logic [4:0] pc, a;
        mm = prog;
        acc = 8'h00; pc = 5'd0;
        m_outs.delete(); m_steps = 0; m_halted = 0;
        while (!m_halted && m_steps < 300) begin
            ir = mm[pc];
            pc = pc + 5'd1;
            a  = ir[4:0];
            m_steps++;
            case (ir[7:5])
                3'd0: acc = mm[a];
                3'd1: mm[a] = acc;
                3'd2: acc = acc + mm[a];
                3'd3: acc = acc - mm[a];
                3'd4: pc = a;
                3'd5: if (acc == 8'h00) pc = a;
                3'd6: m_outs.push_back(acc);
                default: m_halted = 1;
            endcase
        end
    endtask

    task automatic prog_clear();
        foreach (prog[i]) prog[i] = 8'h00;
    endtask

    task automatic lbytes_from_prog();
        lbytes.delete();
        foreach (prog[i]) lbytes.push_back(prog[i]);
    endtask

    // Leaves boot asserted; the caller decides when to release it.
    task automatic load_bytes();
        ui_in[7] = 1'b1;
        tick(3);
        foreach (lbytes[i]) begin
            uio_in = lbytes[i];
            tick(2);
            ui_in[0] = 1'b1;
            tick(4);
            ui_in[0] = 1'b0;
            tick(3);
        end
    endtask

    task automatic release_run(input string name, input bit rnd, input bit freeze,
                               input bit lat_en, input logic [7:0] lat_exp);
        int cyc;
        model_run();
        exp_q.delete();
        exp_q.push_back(last_out);
        foreach (m_outs[i]) if (m_outs[i] != exp_q[$]) exp_q.push_back(m_outs[i]);
        idx = 0;
        obs_q.delete();
        chk_en = 1;
        ena_force0 = freeze;
        ena_rand = rnd;
        ui_in[7] = 1'b0;
        if (freeze) begin
            tick(30);
            check8({name, "_frozen"}, uo_out, last_out);
            ena_force0 = 0;
        end
        en_cnt = 0;
        if (lat_en) begin
            tick(20);
            check8({name, "_lat20"}, uo_out, lat_exp);
        end
        cyc = 0;
        while (en_cnt < 2 * m_steps + 20 && cyc < 4000) begin
            tick(1);
            cyc++;
        end
        checki({name, "_budget"}, (cyc < 4000) ? 1 : 0, 1);
        ena_rand = 0;
        tick(2);
        chk_en = 0;
        check8({name, "_final"}, uo_out, exp_q[$]);
        checki({name, "_seqlen"}, idx, exp_q.size() - 1);
        last_out = exp_q[$];
    endtask

    task automatic prog_t2();
        prog_clear();
        prog[0] = 8'h1E; prog[1] = 8'h5F; prog[2] = 8'hC0; prog[3] = 8'hE0;
        prog[30] = 8'h05; prog[31] = 8'h07;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                ena = ena_force0 ? 1'b0 : (ena_rand ? ($urandom_range(3) != 0) : 1'b1);
            end
            forever begin
                @(posedge clk);
                if (ena) en_cnt++;
            end
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    checks++;
                    if (uo_out === exp_q[idx]) begin
                    end else if (idx + 1 < exp_q.size() && uo_out === exp_q[idx + 1]) begin
                        idx++;
                        obs_q.push_back(uo_out);
                    end else begin
                        errors++;
                        $display("FAIL seq: uo_out=%02h expected %02h at step %0d", uo_out, exp_q[idx], idx);
                    end
                end
            end
        join_none

        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check8("rst_uo_out", uo_out, 8'h00);
        check8("rst_uio_oe", uio_oe, 8'h00);
        check8("rst_uio_out", uio_out, 8'h00);
        tick(2);
        rst_n = 1'b1;
        exp_q.delete(); exp_q.push_back(8'h00); idx = 0;
        chk_en = 1;
        tick(40);
        chk_en = 0;
        check8("idle_uo_out", uo_out, 8'h00);

        // Load + add: 5 + 7 = 0C then halt
        prog_t2();
        lbytes_from_prog();
        load_bytes();
        release_run("t2", 0, 0, 1, 8'h0C);
        check8("t2_model", m_outs[0], 8'h0C);

        // Countdown loop with JZ exit
        prog_clear();
        prog[0] = 8'h1E; prog[1] = 8'h7F; prog[2] = 8'hC0; prog[3] = 8'hA5;
        prog[4] = 8'h81; prog[5] = 8'hE0; prog[30] = 8'h03; prog[31] = 8'h01;
        lbytes_from_prog();
        load_bytes();
        release_run("t3", 0, 0, 0, 8'h00);
        checki("t3_model_n", m_outs.size(), 3);
        check8("t3_model_0", m_outs[0], 8'h02);
        check8("t3_model_2", m_outs[2], 8'h00);
        checki("t3_obs_n", obs_q.size(), 3);
        check8("t3_obs_0", obs_q[0], 8'h02);
        check8("t3_obs_1", obs_q[1], 8'h01);
        check8("t3_obs_2", obs_q[2], 8'h00);

        // ADD wrap and loader address wrap (33rd byte overwrites word 0)
        prog_t2();
        prog[30] = 8'hF0; prog[31] = 8'h20;
        lbytes_from_prog();
        lbytes[0] = 8'hE0;
        lbytes.push_back(8'h1E);
        load_bytes();
        release_run("t4", 0, 0, 0, 8'h00);
        check8("t4_wrap", uo_out, 8'h10);

        // Boot re-asserted mid-run restarts from pc 0
        prog_t2();
        lbytes_from_prog();
        load_bytes();
        ui_in[7] = 1'b0;
        tick(6);
        check8("t6_mid", uo_out, 8'h10);
        ui_in[7] = 1'b1;
        tick(6);
        release_run("t6", 0, 0, 0, 8'h00);
        check8("t6_result", uo_out, 8'h0C);

        // Random programs with random ena gaps
        for (int n = 0; n < 10; n++) begin
            int tries = 0;
            do begin
                foreach (prog[i]) prog[i] = 8'($urandom);
                model_run();
                tries++;
            end while ((!m_halted || m_steps > 120 || m_outs.size() == 0) && tries < 2000);
            lbytes_from_prog();
            load_bytes();
            release_run("rnd", 1, 0, 0, 8'h00);
        end

        // ena=0 freeze then random-ena resume gives the uninterrupted result
        prog_clear();
        prog[0] = 8'h1E; prog[1] = 8'hC0; prog[2] = 8'hE0; prog[30] = 8'h5A;
        lbytes_from_prog();
        load_bytes();
        release_run("t5a", 0, 0, 0, 8'h00);
        check8("t5a_val", uo_out, 8'h5A);
        prog_t2();
        lbytes_from_prog();
        load_bytes();
        release_run("t5", 1, 1, 0, 8'h00);
        check8("t5_result", uo_out, 8'h0C);

        // Async reset mid-operation clears memory too
        rst_n = 1'b0;
        #1;
        check8("rst2_uo_out", uo_out, 8'h00);
        tick(2);
        rst_n = 1'b1;
        last_out = 8'h00;
        exp_q.delete(); exp_q.push_back(8'h00); idx = 0;
        chk_en = 1;
        tick(40);
        chk_en = 0;
        check8("rst2_idle", uo_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
